// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants, receiver FSM states and the 3-3-2 pixel type.
// The generator and the receiver both import this package so their timing cannot drift apart.
package vga_timing_pkg;

  localparam int HPIXELS = 800;
  localparam int VLINES  = 521;
  localparam int HPULSE  = 96;
  localparam int VPULSE  = 2;
  localparam int HBP     = 144;
  localparam int HFP     = 784;
  localparam int VBP     = 31;
  localparam int VFP     = 511;

  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb332_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Input register and falling-edge detector for one active-low sync line.
// fall_o is high in the cycle the first low sample arrives at the input.
module vga_sync_edge (
  input  logic dclk,
  input  logic clr_n,
  input  logic sync_i,
  output logic fall_o
);

  logic sync_q;

  // Syncs idle high, so reset to 1 to avoid a false edge straight after reset.
  always_ff @(posedge dclk) begin
    if (!clr_n) sync_q <= 1'b1;
    else        sync_q <= sync_i;
  end

  assign fall_o = sync_q & ~sync_i;

endmodule

// File: rtl/vga_sync_receiver.sv
// Sink end of the VGA link: recovers pixel coordinates, active video, frame starts and
// line/frame length errors from hsync/vsync/RGB, with a two-stage pipeline (latency 2 dclk).
module vga_sync_receiver #(
  parameter int HPIXELS = vga_timing_pkg::HPIXELS,
  parameter int VLINES  = vga_timing_pkg::VLINES,
  parameter int HBP     = vga_timing_pkg::HBP,
  parameter int HFP     = vga_timing_pkg::HFP,
  parameter int VBP     = vga_timing_pkg::VBP,
  parameter int VFP     = vga_timing_pkg::VFP
) (
  input  logic       dclk,
  input  logic       clr_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] red,
  input  logic [2:0] green,
  input  logic [1:0] blue,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [7:0] pixel_rgb,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err
);

  import vga_timing_pkg::*;

  localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST = 10'(VLINES - 1);
  localparam logic [9:0] H_BP   = 10'(HBP);
  localparam logic [9:0] H_FP   = 10'(HFP);
  localparam logic [9:0] V_BP   = 10'(VBP);
  localparam logic [9:0] V_FP   = 10'(VFP);

  logic      hfall, vfall, frameEdge;
  rgb332_t   rgb_q;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  rx_state_e state_q, state_d;
  logic      dirty_q, dirty_d;
  logic      herr_d, verr_d, fs_d;
  logic      herr_q, verr_q, fs_q;

  logic [9:0] pixel_x_q, pixel_y_q;
  logic [7:0] pixel_rgb_q;
  logic       pixel_valid_q, frame_start_q, locked_q, h_err_q, v_err_q;

  vga_sync_edge u_hedge (.dclk(dclk), .clr_n(clr_n), .sync_i(hsync), .fall_o(hfall));
  vga_sync_edge u_vedge (.dclk(dclk), .clr_n(clr_n), .sync_i(vsync), .fall_o(vfall));

  assign frameEdge = hfall & vfall;

  // Counters index the sample held in stage 1; a vsync edge only matters when it lands on a line start.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (hfall) begin
      hcnt_d = '0;
      if (vfall)                 vcnt_d = '0;
      else if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + 10'd1;
    end
  end

  assign herr_d = hfall     && (state_q != SEARCH) && (hcnt_q != H_LAST);
  assign verr_d = frameEdge && (state_q != SEARCH) && (vcnt_q != V_LAST);

  // dirty_q marks a frame that already saw a line error and therefore cannot qualify for lock.
  always_comb begin
    state_d = state_q;
    dirty_d = dirty_q;
    unique case (state_q)
      SEARCH: begin
        if (frameEdge) begin
          state_d = TRACK;
          dirty_d = 1'b0;
        end
      end
      TRACK: begin
        if (herr_d) dirty_d = 1'b1;
        if (frameEdge) begin
          if (!dirty_q && !herr_d && !verr_d) state_d = LOCKED;
          dirty_d = 1'b0;
        end
      end
      LOCKED: begin
        if (herr_d || verr_d) begin
          state_d = TRACK;
          // A mid-frame error taints the rest of that frame; one on a frame edge starts clean.
          dirty_d = ~frameEdge;
        end
      end
      default: begin
        state_d = SEARCH;
        dirty_d = 1'b0;
      end
    endcase
  end

  assign fs_d = vfall && (state_d == LOCKED);

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      rgb_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      state_q <= SEARCH;
      dirty_q <= 1'b0;
      herr_q  <= 1'b0;
      verr_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= '{red: red, green: green, blue: blue};
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      state_q <= state_d;
      dirty_q <= dirty_d;
      herr_q  <= herr_d;
      verr_q  <= verr_d;
      fs_q    <= fs_d;
    end
  end

  // Stage 2: the lock decision made on a sync edge already gates the pixel that follows it.
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_rgb_q   <= '0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
    end else begin
      pixel_x_q     <= hcnt_q - H_BP;
      pixel_y_q     <= vcnt_q - V_BP;
      pixel_rgb_q   <= rgb_q;
      pixel_valid_q <= (state_q == LOCKED) && (hcnt_q >= H_BP) && (hcnt_q < H_FP) &&
                       (vcnt_q >= V_BP) && (vcnt_q < V_FP);
      frame_start_q <= fs_q;
      locked_q      <= (state_q == LOCKED);
      h_err_q       <= herr_q;
      v_err_q       <= verr_q;
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;

endmodule
